wb2bp_convertor: RTL and testbench

WB2BP_CONVERTOR -- requirements
Module: wb2bp_convertor

---
 rtl/wb2bp_convertor.sv | 233 +++++++++++++++++++++++
 tb/tb_wb2bp_convertor.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb2bp_convertor.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : wb2bp_convertor                                          |
// | Description : Wishbone classic slave to BlackParrot uncached IO        |
// |               command/response bridge. One transaction at a time:     |
// |               IDLE -> SEND -> WAIT -> ACK, with ERR for illegal byte   |
// |               selects or a response timeout.                           |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module wb2bp_convertor #(
   parameter int          paddr_width_p  = 40,
   parameter int          wb_adr_width_p = 37,
   parameter int          timeout_p      = 255,
   parameter logic [3:0]  uc_rd_code_p   = 4'b0010,
   parameter logic [3:0]  uc_wr_code_p   = 4'b0011
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,

   // Wishbone slave
   input  logic [wb_adr_width_p-1:0]  adr_i,
   input  logic [63:0]                dat_i,
   output logic [63:0]                dat_o,
   input  logic [7:0]                 sel_i,
   input  logic                       cyc_i,
   input  logic                       stb_i,
   input  logic                       we_i,
   input  logic [2:0]                 cti_i,
   input  logic [1:0]                 bte_i,
   output logic                       ack_o,
   output logic                       err_o,

   // BlackParrot IO command
   output logic [3:0]                 io_cmd_msg_type_o,
   output logic [paddr_width_p-1:0]   io_cmd_addr_o,
   output logic [2:0]                 io_cmd_size_o,
   output logic [63:0]                io_cmd_data_o,
   output logic                       io_cmd_v_o,
   input  logic                       io_cmd_ready_i,

   // BlackParrot IO response
   input  logic [63:0]                io_resp_data_i,
   input  logic                       io_resp_v_i,
   output logic                       io_resp_yumi_o
);

   localparam logic [15:0] c_timeout = 16'(timeout_p);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SEND = 3'd1,
      S_WAIT = 3'd2,
      S_ACK  = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   state_t                     r_state;
   state_t                     w_next_state;
   logic [15:0]                r_cnt;
   logic                       r_abort;
   logic [7:0]                 r_sel;
   logic [2:0]                 r_offset;
   logic [2:0]                 r_size;
   logic [3:0]                 r_type;
   logic [paddr_width_p-1:0]   r_addr;
   logic [63:0]                r_data;
   logic [63:0]                r_dat_o;

   logic                       w_start;
   logic                       w_sel_legal;
   logic [2:0]                 w_offset;
   logic [2:0]                 w_size;
   logic [63:0]                w_size_mask;
   logic [63:0]                w_cmd_data;
   logic [paddr_width_p-1:0]   w_cmd_addr;
   logic [63:0]                w_lane_mask;
   logic [63:0]                w_resp_aligned;
   logic                       w_unused;

   // Burst hints carry no meaning here: every strobe is a single transfer.
   assign w_unused = ^{cti_i, bte_i};

   // A new Wishbone request is only taken while idle.
   assign w_start = (r_state == S_IDLE) && cyc_i && stb_i;

   // Decode the byte select into naturally aligned size and lowest byte offset.
   always_comb begin
      w_sel_legal = 1'b1;
      w_size      = 3'd0;
      w_offset    = 3'd0;
      case (sel_i)
         8'h01: begin w_size = 3'd0; w_offset = 3'd0; end
         8'h02: begin w_size = 3'd0; w_offset = 3'd1; end
         8'h04: begin w_size = 3'd0; w_offset = 3'd2; end
         8'h08: begin w_size = 3'd0; w_offset = 3'd3; end
         8'h10: begin w_size = 3'd0; w_offset = 3'd4; end
         8'h20: begin w_size = 3'd0; w_offset = 3'd5; end
         8'h40: begin w_size = 3'd0; w_offset = 3'd6; end
         8'h80: begin w_size = 3'd0; w_offset = 3'd7; end
         8'h03: begin w_size = 3'd1; w_offset = 3'd0; end
         8'h0C: begin w_size = 3'd1; w_offset = 3'd2; end
         8'h30: begin w_size = 3'd1; w_offset = 3'd4; end
         8'hC0: begin w_size = 3'd1; w_offset = 3'd6; end
         8'h0F: begin w_size = 3'd2; w_offset = 3'd0; end
         8'hF0: begin w_size = 3'd2; w_offset = 3'd4; end
         8'hFF: begin w_size = 3'd3; w_offset = 3'd0; end
         default: w_sel_legal = 1'b0;
      endcase
   end

   // Keep only the bytes that the command size covers after alignment.
   always_comb begin
      w_size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      case (w_size)
         3'd0:    w_size_mask = 64'h0000_0000_0000_00FF;
         3'd1:    w_size_mask = 64'h0000_0000_0000_FFFF;
         3'd2:    w_size_mask = 64'h0000_0000_FFFF_FFFF;
         default: w_size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
   end

   assign w_cmd_data = (dat_i >> {w_offset, 3'b000}) & w_size_mask;
   assign w_cmd_addr = paddr_width_p'({adr_i, 3'b000}) + paddr_width_p'(w_offset);

   // Expand the latched byte select into a 64-bit lane mask for read data.
   always_comb begin
      w_lane_mask = '0;
      for (int i = 0; i < 8; i++) begin
         w_lane_mask[8*i +: 8] = {8{r_sel[i]}};
      end
   end

   assign w_resp_aligned = (io_resp_data_i << {r_offset, 3'b000}) & w_lane_mask;

   // State register.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (cyc_i && stb_i) begin
               w_next_state = w_sel_legal ? S_SEND : S_ERR;
            end
         end
         S_SEND: begin
            if (io_cmd_ready_i) begin
               w_next_state = S_WAIT;
            end
         end
         S_WAIT: begin
            if (io_resp_v_i) begin
               w_next_state = S_ACK;
            end else if (r_cnt == c_timeout) begin
               w_next_state = S_ERR;
            end
         end
         S_ACK:   w_next_state = S_IDLE;
         S_ERR:   w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Response timeout counter: zero outside WAIT, counts every WAIT cycle.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_cnt <= '0;
      end else if (r_state == S_WAIT) begin
         r_cnt <= r_cnt + 16'd1;
      end else begin
         r_cnt <= '0;
      end
   end

   // Remember that the master walked away so the termination is swallowed.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_abort <= 1'b0;
      end else if (w_start) begin
         r_abort <= 1'b0;
      end else if (((r_state == S_SEND) || (r_state == S_WAIT)) && !cyc_i) begin
         r_abort <= 1'b1;
      end
   end

   // Capture the request and pre-format the command fields when it is accepted.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_sel    <= '0;
         r_offset <= '0;
         r_size   <= '0;
         r_type   <= '0;
         r_addr   <= '0;
         r_data   <= '0;
      end else if (w_start) begin
         r_sel    <= sel_i;
         r_offset <= w_offset;
         r_size   <= w_size;
         r_type   <= we_i ? uc_wr_code_p : uc_rd_code_p;
         r_addr   <= w_cmd_addr;
         r_data   <= w_cmd_data;
      end
   end

   // Read data is re-aligned onto its Wishbone lanes and then held.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_dat_o <= '0;
      end else if ((r_state == S_WAIT) && io_resp_v_i) begin
         r_dat_o <= w_resp_aligned;
      end
   end

   assign dat_o             = r_dat_o;
   assign ack_o             = (r_state == S_ACK) && !r_abort;
   assign err_o             = (r_state == S_ERR) && !r_abort;
   assign io_cmd_v_o        = (r_state == S_SEND);
   assign io_cmd_msg_type_o = r_type;
   assign io_cmd_addr_o     = r_addr;
   assign io_cmd_size_o     = r_size;
   assign io_cmd_data_o     = r_data;
   // Responses are always consumed; outside WAIT they are simply dropped.
   assign io_resp_yumi_o    = io_resp_v_i && reset_n_i;

endmodule
`default_nettype wire

// File: tb/tb_wb2bp_convertor.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_wb2bp_convertor                                       |
// | Description : Directed self-checking bench for wb2bp_convertor.        |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_wb2bp_convertor;

   logic          clk;
   logic          reset_n;
   logic [36:0]   adr;
   logic [63:0]   dat_in;
   logic [63:0]   dat_out;
   logic [7:0]    sel;
   logic          cyc;
   logic          stb;
   logic          we;
   logic [2:0]    cti;
   logic [1:0]    bte;
   logic          ack;
   logic          err;
   logic [3:0]    cmd_type;
   logic [39:0]   cmd_addr;
   logic [2:0]    cmd_size;
   logic [63:0]   cmd_data;
   logic          cmd_v;
   logic          cmd_ready;
   logic [63:0]   resp_data;
   logic          resp_v;
   logic          resp_yumi;

   int checks   = 0;
   int failures = 0;

   wb2bp_convertor #(
      .paddr_width_p  (40),
      .wb_adr_width_p (37),
      .timeout_p      (8),
      .uc_rd_code_p   (4'b0010),
      .uc_wr_code_p   (4'b0011)
   ) dut (
      .clk_i             (clk),
      .reset_n_i         (reset_n),
      .adr_i             (adr),
      .dat_i             (dat_in),
      .dat_o             (dat_out),
      .sel_i             (sel),
      .cyc_i             (cyc),
      .stb_i             (stb),
      .we_i              (we),
      .cti_i             (cti),
      .bte_i             (bte),
      .ack_o             (ack),
      .err_o             (err),
      .io_cmd_msg_type_o (cmd_type),
      .io_cmd_addr_o     (cmd_addr),
      .io_cmd_size_o     (cmd_size),
      .io_cmd_data_o     (cmd_data),
      .io_cmd_v_o        (cmd_v),
      .io_cmd_ready_i    (cmd_ready),
      .io_resp_data_i    (resp_data),
      .io_resp_v_i       (resp_v),
      .io_resp_yumi_o    (resp_yumi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request, let it be sampled, land one cycle later.
   task automatic wb_start(input logic w, input logic [36:0] a, input logic [7:0] s,
                           input logic [63:0] d);
      cyc    = 1'b1;
      stb    = 1'b1;
      we     = w;
      adr    = a;
      sel    = s;
      dat_in = d;
      tick();
   endtask

   task automatic wb_drop();
      cyc = 1'b0;
      stb = 1'b0;
   endtask

   initial begin
      reset_n   = 1'b0;
      adr       = '0;
      dat_in    = '0;
      sel       = '0;
      cyc       = 1'b0;
      stb       = 1'b0;
      we        = 1'b0;
      cti       = 3'b111;
      bte       = 2'b01;
      cmd_ready = 1'b0;
      resp_data = '0;
      resp_v    = 1'b1;

      // Reset values
      tick();
      tick();
      check("rst_ack",   ack, 0);
      check("rst_err",   err, 0);
      check("rst_cmdv",  cmd_v, 0);
      check("rst_yumi",  resp_yumi, 0);
      check("rst_dato",  dat_out, 0);
      check("rst_addr",  cmd_addr, 0);
      check("rst_data",  cmd_data, 0);
      check("rst_size",  cmd_size, 0);
      check("rst_type",  cmd_type, 0);
      resp_v  = 1'b0;
      reset_n = 1'b1;
      tick();

      // Full-word write, minimum latency
      cmd_ready = 1'b1;
      wb_start(1'b1, 37'h10, 8'hFF, 64'h1122334455667788);
      check("wr_cmdv",  cmd_v, 1);
      check("wr_addr",  cmd_addr, 64'h80);
      check("wr_size",  cmd_size, 3);
      check("wr_data",  cmd_data, 64'h1122334455667788);
      check("wr_type",  cmd_type, 4'b0011);
      check("wr_ack_c1", ack, 0);
      tick();
      check("wr_cmdv_c2", cmd_v, 0);
      resp_v    = 1'b1;
      resp_data = 64'h0;
      #1;
      check("wr_yumi", resp_yumi, 1);
      tick();
      resp_v = 1'b0;
      check("wr_ack_c3", ack, 1);
      check("wr_err_c3", err, 0);
      wb_drop();
      tick();
      check("wr_ack_end", ack, 0);

      // Single byte read from lane 5
      wb_start(1'b0, 37'h2, 8'h20, 64'hFFEEDDCCBBAA9988);
      check("rd_addr", cmd_addr, 64'h15);
      check("rd_size", cmd_size, 0);
      check("rd_type", cmd_type, 4'b0010);
      check("rd_data", cmd_data, 64'hDD);
      tick();
      resp_v    = 1'b1;
      resp_data = 64'h123456789ABCDEAB;
      tick();
      resp_v = 1'b0;
      check("rd_ack",  ack, 1);
      check("rd_dato", dat_out, 64'h0000AB0000000000);
      wb_drop();
      tick();
      check("rd_dato_hold", dat_out, 64'h0000AB0000000000);

      // Illegal select
      wb_start(1'b0, 37'h7, 8'h05, 64'h0);
      check("ill_err",  err, 1);
      check("ill_ack",  ack, 0);
      check("ill_cmdv", cmd_v, 0);
      wb_drop();
      tick();
      check("ill_err_end", err, 0);
      check("ill_cmdv_end", cmd_v, 0);

      // Backpressure: ready low for 5 cycles, 16-bit write at lanes 2..3
      cmd_ready = 1'b0;
      wb_start(1'b1, 37'h4, 8'h0C, 64'h00000000BEEF0000);
      for (int i = 0; i < 5; i++) begin
         check("bp_cmdv", cmd_v, 1);
         check("bp_addr", cmd_addr, 64'h22);
         check("bp_data", cmd_data, 64'hBEEF);
         check("bp_size", cmd_size, 1);
         tick();
      end
      cmd_ready = 1'b1;
      check("bp_cmdv6", cmd_v, 1);
      tick();
      check("bp_cmdv_off", cmd_v, 0);
      resp_v = 1'b1;
      tick();
      resp_v = 1'b0;
      check("bp_ack", ack, 1);
      wb_drop();
      tick();
      check("bp_ack_once", ack, 0);

      // Timeout: no response for the whole WAIT window
      wb_start(1'b0, 37'h1, 8'hF0, 64'h0);
      check("to_addr", cmd_addr, 64'hC);
      check("to_size", cmd_size, 2);
      tick();
      for (int i = 0; i < 9; i++) begin
         check("to_wait_err", err, 0);
         tick();
      end
      check("to_err", err, 1);
      check("to_ack", ack, 0);
      wb_drop();
      tick();
      check("to_err_end", err, 0);
      resp_v = 1'b1;
      #1;
      check("to_late_yumi", resp_yumi, 1);
      tick();
      resp_v = 1'b0;
      check("to_late_ack", ack, 0);
      check("to_late_cmdv", cmd_v, 0);
      tick();
      check("to_late_ack2", ack, 0);

      // Abort: cyc dropped while waiting, response arrives afterwards
      wb_start(1'b0, 37'h3, 8'h01, 64'h0);
      tick();
      wb_drop();
      tick();
      resp_v    = 1'b1;
      resp_data = 64'h55;
      #1;
      check("ab_yumi", resp_yumi, 1);
      tick();
      resp_v = 1'b0;
      check("ab_ack", ack, 0);
      check("ab_err", err, 0);
      tick();
      check("ab_ack2", ack, 0);

      // Reset asserted while a command is pending
      cmd_ready = 1'b0;
      wb_start(1'b1, 37'h9, 8'hFF, 64'hCAFE);
      check("rs_cmdv_pre", cmd_v, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("rs_cmdv", cmd_v, 0);
      check("rs_addr", cmd_addr, 0);
      check("rs_ack",  ack, 0);
      wb_drop();
      tick();
      reset_n = 1'b1;
      tick();
      check("rs_err_after", err, 0);
      resp_v = 1'b1;
      #1;
      check("rs_first_yumi", resp_yumi, 1);
      tick();
      resp_v = 1'b0;
      check("rs_first_ack", ack, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
